// File: rtl/unpool_upsample_2x.sv
// Streaming 2x2 unpooling: each pooled pixel becomes a 2x2 cell, either replicated
// (nearest) or placed top-left with zeros elsewhere. The second row of each cell pair comes from a line buffer.
module unpool_upsample_2x #(
  parameter int DATA_W = 8,
  parameter int IN_W   = 8,
  parameter int IN_H   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  typedef enum logic {PH_A, PH_B} phase_t;

  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              frame_done_reg;
  logic              dup_reg;
  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  phase_t            phase_reg;
  logic              mode_q_reg;

  logic [DATA_W-1:0] lb [IN_W];

  logic              dup_next;
  logic [CW-1:0]     col_next;
  logic [RW-1:0]     row_next;
  phase_t            phase_next;
  logic              frame_end;
  logic              need_in_next;
  logic              out_fire;
  logic              in_fire;
  logic [CW-1:0]     ld_col;
  logic [RW-1:0]     ld_row;
  logic [DATA_W-1:0] beat_value;

  // Position of the beat that follows the one currently in the output register.
  always_comb begin
    dup_next   = ~dup_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    phase_next = phase_reg;
    frame_end  = 1'b0;
    if (dup_reg) begin
      if (col_reg != COL_LAST) begin
        col_next = col_reg + 1'b1;
      end else begin
        col_next = '0;
        if (phase_reg == PH_A) begin
          phase_next = PH_B;
        end else begin
          phase_next = PH_A;
          if (row_reg != ROW_LAST) begin
            row_next = row_reg + 1'b1;
          end else begin
            row_next  = '0;
            frame_end = 1'b1;
          end
        end
      end
    end
  end

  // A fresh pixel is needed only for a phase-A dup-0 beat inside the current frame;
  // the frame's first pixel waits for the frame_done cycle to pass.
  assign need_in_next = dup_reg && (phase_next == PH_A) && !frame_end;
  assign out_fire     = out_valid_reg && out_ready;
  assign in_ready     = !frame_done_reg &&
                        (out_valid_reg ? (out_ready && need_in_next) : (phase_reg == PH_A));
  assign in_fire      = in_valid && in_ready;

  assign ld_col = out_valid_reg ? col_next : col_reg;
  assign ld_row = out_valid_reg ? row_next : row_reg;

  always_comb begin
    beat_value = '0;
    if (mode_q_reg) begin
      beat_value = (phase_next == PH_A) ? out_data_reg : lb[col_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      dup_reg        <= 1'b0;
      col_reg        <= '0;
      row_reg        <= '0;
      phase_reg      <= PH_A;
      mode_q_reg     <= 1'b1;
    end else begin
      frame_done_reg <= out_fire && frame_end;
      if (in_fire && (ld_row == '0) && (ld_col == '0)) begin
        mode_q_reg <= mode;
      end
      if (out_fire) begin
        dup_reg   <= dup_next;
        col_reg   <= col_next;
        row_reg   <= row_next;
        phase_reg <= phase_next;
        if (need_in_next) begin
          out_valid_reg <= in_fire;
          if (in_fire) begin
            out_data_reg <= in_data;
          end
        end else if (frame_end) begin
          out_valid_reg <= 1'b0;
        end else begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= beat_value;
        end
      end else if (!out_valid_reg && in_fire) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= in_data;
      end
    end
  end

  // Line buffer has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && in_fire) begin
      lb[ld_col] <= in_data;
    end
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_unpool_upsample_2x.sv
// Directed bench for unpool_upsample_2x: three instances (2x2, 4x3, 1x1) share one clock.
module tb_unpool_upsample_2x;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] rst_v, mode_v, in_valid_v, in_ready_v, out_valid_v, out_ready_v, frame_done_v;
  logic [7:0] in_data_v [3];
  logic [7:0] out_data_v [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      unpool_upsample_2x #(
        .DATA_W(8),
        .IN_W  (gi == 0 ? 2 : (gi == 1 ? 4 : 1)),
        .IN_H  (gi == 0 ? 2 : (gi == 1 ? 3 : 1))
      ) dut (
        .clk       (clk),
        .rst       (rst_v[gi]),
        .mode      (mode_v[gi]),
        .in_data   (in_data_v[gi]),
        .in_valid  (in_valid_v[gi]),
        .in_ready  (in_ready_v[gi]),
        .out_data  (out_data_v[gi]),
        .out_valid (out_valid_v[gi]),
        .out_ready (out_ready_v[gi]),
        .frame_done(frame_done_v[gi])
      );
    end
  endgenerate

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pix_q [$];
  logic [7:0] obs_q [$];
  int         obs_cyc_q [$];
  int         done_q [$];
  int         stab_bad;
  int         order_bad;

  function automatic int w_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
  endfunction

  // Drives one frame into instance d and records beats, frame_done cycles,
  // stall-stability violations and out-of-place input acceptances.
  task automatic capture(input int d, input int npix, input int stop_beats,
                         input logic m0, input logic m1, input int toggle_at,
                         input bit rnd, input int budget);
    int p = 0;
    int w = w_of(d);
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    obs_q.delete();
    obs_cyc_q.delete();
    done_q.delete();
    stab_bad  = 0;
    order_bad = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      in_valid_v[d]  = (p < npix) && (!rnd || ($urandom_range(0, 1) == 1));
      in_data_v[d]   = (p < npix) ? pix_q[p] : 8'h00;
      mode_v[d]      = (p >= toggle_at) ? m1 : m0;
      out_ready_v[d] = !rnd || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (prev_stall && (!out_valid_v[d] || out_data_v[d] !== prev_data)) stab_bad++;
      prev_stall = out_valid_v[d] && !out_ready_v[d];
      prev_data  = out_data_v[d];
      if (frame_done_v[d]) done_q.push_back(cyc);
      if (out_valid_v[d] && out_ready_v[d]) begin
        obs_q.push_back(out_data_v[d]);
        obs_cyc_q.push_back(cyc);
      end
      if (in_valid_v[d] && in_ready_v[d]) begin
        if (obs_q.size() != (p / w) * 4 * w + 2 * (p % w)) order_bad++;
        p++;
      end
      if (stop_beats > 0 && obs_q.size() >= stop_beats) break;
      if (done_q.size() > 0 && obs_q.size() >= 4 * npix) break;
    end
    in_valid_v[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst_v = 3'b111;
    mode_v = 3'b111;
    in_valid_v = 3'b000;
    out_ready_v = 3'b111;
    for (int d = 0; d < 3; d++) in_data_v[d] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_v = 3'b000;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if (out_valid_v[d] !== 1'b0 || out_data_v[d] !== 8'h00 ||
          frame_done_v[d] !== 1'b0 || in_ready_v[d] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_state dut%0d: got v=%b d=%h fd=%b rdy=%b, want v=0 d=00 fd=0 rdy=1",
                 d, out_valid_v[d], out_data_v[d], frame_done_v[d], in_ready_v[d]);
      end
    end
  endtask

  task automatic test_nearest_2x2;
    logic [7:0] exp_t [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
    logic [7:0] got;
    pix_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    capture(0, 4, 0, 1'b1, 1'b1, 0, 0, 200);
    n_vec++;
    if (obs_q.size() != 16) begin
      n_err++;
      $display("FAIL nearest_count: got %0d beats, want 16", obs_q.size());
    end
    for (int k = 0; k < 16; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 8'hxx;
      n_vec++;
      if (got !== exp_t[k]) begin
        n_err++;
        $display("FAIL nearest_beat%0d: got %h want %h", k, got, exp_t[k]);
      end
    end
    n_vec++;
    if (obs_q.size() == 16 && obs_cyc_q[15] - obs_cyc_q[0] != 15) begin
      n_err++;
      $display("FAIL nearest_no_bubble: span %0d cycles want 15", obs_cyc_q[15] - obs_cyc_q[0]);
    end
    n_vec++;
    if (done_q.size() != 1 || obs_q.size() != 16 || done_q[0] != obs_cyc_q[15] + 1) begin
      n_err++;
      $display("FAIL nearest_frame_done: got %0d pulses, want 1 pulse the cycle after beat 16", done_q.size());
    end
    n_vec++;
    if (order_bad != 0) begin
      n_err++;
      $display("FAIL nearest_accept_order: got %0d misplaced inputs want 0", order_bad);
    end
    @(negedge clk);
    n_vec++;
    if (frame_done_v[0] !== 1'b0) begin
      n_err++;
      $display("FAIL nearest_done_width: got frame_done=%b want 0", frame_done_v[0]);
    end
  endtask

  task automatic test_zero_2x2;
    logic [7:0] exp_t [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
    logic [7:0] got;
    pix_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    capture(0, 4, 0, 1'b0, 1'b0, 0, 0, 200);
    for (int k = 0; k < 16; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 8'hxx;
      n_vec++;
      if (got !== exp_t[k]) begin
        n_err++;
        $display("FAIL zero_beat%0d: got %h want %h", k, got, exp_t[k]);
      end
    end
    n_vec++;
    if (done_q.size() != 1) begin
      n_err++;
      $display("FAIL zero_frame_done: got %0d pulses want 1", done_q.size());
    end
  endtask

  task automatic test_mode_toggle;
    logic [7:0] exp_n [16] = '{9,9,10,10, 9,9,10,10, 11,11,12,12, 11,11,12,12};
    logic [7:0] exp_z [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
    logic [7:0] got;
    pix_q = '{8'd9, 8'd10, 8'd11, 8'd12};
    capture(0, 4, 0, 1'b1, 1'b0, 2, 0, 200);
    for (int k = 0; k < 16; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 8'hxx;
      n_vec++;
      if (got !== exp_n[k]) begin
        n_err++;
        $display("FAIL toggle_frame1_beat%0d: got %h want %h", k, got, exp_n[k]);
      end
    end
    pix_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    capture(0, 4, 0, 1'b0, 1'b0, 0, 0, 200);
    for (int k = 0; k < 16; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 8'hxx;
      n_vec++;
      if (got !== exp_z[k]) begin
        n_err++;
        $display("FAIL toggle_frame2_beat%0d: got %h want %h", k, got, exp_z[k]);
      end
    end
  endtask

  task automatic test_random_4x3;
    logic [7:0] exp_b [48];
    logic [7:0] got;
    int k = 0;
    pix_q.delete();
    for (int i = 0; i < 12; i++) pix_q.push_back(8'h10 + 8'(i));
    for (int r = 0; r < 3; r++)
      for (int ph = 0; ph < 2; ph++)
        for (int c = 0; c < 4; c++)
          for (int dp = 0; dp < 2; dp++) begin
            exp_b[k] = 8'h10 + 8'(r * 4 + c);
            k++;
          end
    capture(1, 12, 0, 1'b1, 1'b1, 0, 1, 2000);
    n_vec++;
    if (obs_q.size() != 48) begin
      n_err++;
      $display("FAIL random_count: got %0d beats want 48", obs_q.size());
    end
    for (int j = 0; j < 48; j++) begin
      got = (j < obs_q.size()) ? obs_q[j] : 8'hxx;
      n_vec++;
      if (got !== exp_b[j]) begin
        n_err++;
        $display("FAIL random_beat%0d: got %h want %h", j, got, exp_b[j]);
      end
    end
    n_vec++;
    if (stab_bad != 0) begin
      n_err++;
      $display("FAIL random_stall_stable: got %0d unstable stalls want 0", stab_bad);
    end
    n_vec++;
    if (order_bad != 0) begin
      n_err++;
      $display("FAIL random_accept_order: got %0d misplaced inputs want 0", order_bad);
    end
    n_vec++;
    if (done_q.size() != 1) begin
      n_err++;
      $display("FAIL random_frame_done: got %0d pulses want 1", done_q.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_t [16] = '{5,5,6,6, 5,5,6,6, 7,7,8,8, 7,7,8,8};
    logic [7:0] got;
    pix_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    capture(0, 4, 5, 1'b1, 1'b1, 0, 0, 200);
    @(posedge clk);
    #1 rst_v[0] = 1'b1;
    @(posedge clk);
    #1 rst_v[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || out_data_v[0] !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_state: got v=%b rdy=%b d=%h, want v=0 rdy=1 d=00",
               out_valid_v[0], in_ready_v[0], out_data_v[0]);
    end
    pix_q = '{8'd5, 8'd6, 8'd7, 8'd8};
    capture(0, 4, 0, 1'b1, 1'b1, 0, 0, 200);
    for (int k = 0; k < 16; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 8'hxx;
      n_vec++;
      if (got !== exp_t[k]) begin
        n_err++;
        $display("FAIL reset_mid_beat%0d: got %h want %h", k, got, exp_t[k]);
      end
    end
  endtask

  task automatic test_1x1;
    logic [7:0] exp_n [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp_z [4] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] got;
    pix_q = '{8'hFF};
    capture(2, 1, 0, 1'b1, 1'b1, 0, 0, 100);
    for (int k = 0; k < 4; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 8'hxx;
      n_vec++;
      if (got !== exp_n[k]) begin
        n_err++;
        $display("FAIL one_nearest_beat%0d: got %h want %h", k, got, exp_n[k]);
      end
    end
    n_vec++;
    if (done_q.size() != 1 || obs_q.size() != 4 || done_q[0] != obs_cyc_q[3] + 1) begin
      n_err++;
      $display("FAIL one_frame_done: got %0d pulses/%0d beats want 1 pulse after 4 beats",
               done_q.size(), obs_q.size());
    end
    capture(2, 1, 0, 1'b0, 1'b0, 0, 0, 100);
    for (int k = 0; k < 4; k++) begin
      got = (k < obs_q.size()) ? obs_q[k] : 8'hxx;
      n_vec++;
      if (got !== exp_z[k]) begin
        n_err++;
        $display("FAIL one_zero_beat%0d: got %h want %h", k, got, exp_z[k]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nearest_2x2();
    test_zero_2x2();
    test_mode_toggle();
    test_random_4x3();
    test_reset_mid();
    test_1x1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
